// File: rtl/mips_cpu_pkg.sv
// Shared types and defaults for the multi-cycle MIPS core's PC sequencing.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    SLOT   = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam word_t DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam word_t DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_seq.sv
// PC sequencer: sequential fetch, branch-delay-slot redirects and halt-on-redirect detection.
module mips_cpu_pc_seq
  import mips_cpu_pkg::*;
#(
  parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter word_t HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic        delay_slot,
  output logic        active,
  output logic        redirect_ack,
  output logic        slot_err,
  output logic [31:0] pending_target
);

  pc_state_t state_q, state_d;
  word_t     pc_q, pc_d;
  word_t     pending_q, pending_d;
  logic      ack_q, ack_d;
  logic      err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SEQ;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    case (state_q)
      SEQ: begin
        if (instr_done) begin
          pc_d = pc_q + 32'd4;
          if (redirect_valid) begin
            pending_d = redirect_target & ~32'h3;
            state_d   = SLOT;
            ack_d     = 1'b1;
          end
        end
      end
      SLOT: begin
        // A branch sitting in the delay slot is dropped; the first target still wins.
        if (instr_done) begin
          pc_d      = pending_q;
          pending_d = '0;
          state_d   = (pending_q == HALT_ADDR) ? HALTED : SEQ;
          if (redirect_valid) err_d = 1'b1;
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  assign pc             = pc_q;
  assign delay_slot     = (state_q == SLOT);
  assign active         = (state_q != HALTED);
  assign redirect_ack   = ack_q;
  assign slot_err       = err_q;
  assign pending_target = pending_q;

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Directed bench for mips_cpu_pc_seq with a cycle-level reference model and literal spot checks.
module tb_mips_cpu_pc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_done = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] pc;
  logic        delay_slot;
  logic        active;
  logic        redirect_ack;
  logic        slot_err;
  logic [31:0] pending_target;

  always #5 clk = ~clk;

  mips_cpu_pc_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_done     (instr_done),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc             (pc),
    .delay_slot     (delay_slot),
    .active         (active),
    .redirect_ack   (redirect_ack),
    .slot_err       (slot_err),
    .pending_target (pending_target)
  );

  // Reference model: "in_slot" means the next retirement is a delay-slot instruction.
  logic [31:0] m_pc;
  logic [31:0] m_pending;
  logic        m_in_slot, m_halted, m_ack, m_err;
  bit          model_valid = 0;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update(input bit rst, input bit done, input bit rv, input logic [31:0] tgt);
    if (!rst) begin
      m_pc = 32'hBFC0_0000; m_pending = 0; m_in_slot = 0; m_halted = 0; m_ack = 0; m_err = 0;
    end else begin
      m_ack = 0;
      if (!m_halted && done) begin
        if (m_in_slot) begin
          if (rv) m_err = 1;
          m_pc = m_pending;
          m_halted = (m_pending == 32'h0);
          m_in_slot = 0;
          m_pending = 0;
        end else begin
          m_pc = m_pc + 32'd4;
          if (rv) begin
            m_pending = {tgt[31:2], 2'b00};
            m_in_slot = 1;
            m_ack = 1;
          end
        end
      end
    end
  endtask

  // One clock of stimulus: drive on the falling edge, model advances after the rising edge.
  task automatic step(input bit rst, input bit done, input bit rv, input logic [31:0] tgt);
    @(negedge clk);
    rst_n = rst; instr_done = done; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    #1;
    model_update(rst, done, rv, tgt);
    model_valid = 1;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("pc", pc, m_pc);
      chk("delay_slot", {31'd0, delay_slot}, {31'd0, m_in_slot});
      chk("active", {31'd0, active}, {31'd0, ~m_halted});
      chk("redirect_ack", {31'd0, redirect_ack}, {31'd0, m_ack});
      chk("slot_err", {31'd0, slot_err}, {31'd0, m_err});
      chk("pending_target", pending_target, m_pending);
    end
  end

  initial begin
    // Reset state
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h1234);
    chk("lit_reset_pc", pc, 32'hBFC0_0000);
    chk("lit_reset_active", {31'd0, active}, 32'd1);

    // Plain sequential fetch
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("lit_seq_pc", pc, 32'hBFC0_000C);
    step(1, 0, 1, 32'hDEAD_BEEC);
    chk("lit_rv_without_done", pc, 32'hBFC0_000C);

    // Basic redirect with delay slot
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'hBFC0_0100);
    chk("lit_slot_pc", pc, 32'hBFC0_0008);
    chk("lit_slot_ds", {31'd0, delay_slot}, 32'd1);
    chk("lit_slot_ack", {31'd0, redirect_ack}, 32'd1);
    step(1, 0, 0, 0);
    chk("lit_ack_pulse", {31'd0, redirect_ack}, 32'd0);
    step(1, 1, 0, 0);
    chk("lit_target_pc", pc, 32'hBFC0_0100);

    // Unaligned target, then a branch inside the delay slot
    step(1, 1, 1, 32'hBFC0_0203);
    chk("lit_pending_aligned", pending_target, 32'hBFC0_0200);
    step(1, 1, 1, 32'hBFC0_0300);
    chk("lit_slot_branch_pc", pc, 32'hBFC0_0200);
    chk("lit_slot_err", {31'd0, slot_err}, 32'd1);

    // Sequential wrap past 0xFFFFFFFC must not halt
    step(1, 1, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("lit_wrap_pre", pc, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("lit_wrap_pc", pc, 32'h0000_0000);
    chk("lit_wrap_active", {31'd0, active}, 32'd1);

    // Halt via redirect to address 0
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h0000_0000);
    chk("lit_halt_slot_pc", pc, 32'h0000_0008);
    step(1, 1, 0, 0);
    chk("lit_halt_pc", pc, 32'h0);
    chk("lit_halt_active", {31'd0, active}, 32'd0);
    step(1, 1, 1, 32'h0000_0120);
    step(1, 1, 0, 0);
    chk("lit_halted_hold", pc, 32'h0);

    // Reset mid-slot clears pending target and sticky error
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0500);
    step(1, 1, 1, 32'h0000_0600);
    chk("lit_err_again", {31'd0, slot_err}, 32'd1);
    step(1, 1, 1, 32'h0000_0700);
    step(1, 0, 0, 0);
    chk("lit_slot_hold", pc, 32'h0000_0504);
    step(0, 0, 0, 0);
    chk("lit_rst_pc", pc, 32'hBFC0_0000);
    chk("lit_rst_pending", pending_target, 32'h0);
    chk("lit_rst_err", {31'd0, slot_err}, 32'd0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
